// File: rtl/edge_bit_morph_3x3.sv
// rtl/edge_bit_morph_3x3.sv - 3x3 binary dilate/erode on a 1-bit edge stream
// Output is centred one row and one column behind the newest input pixel.
module edge_bit_morph_3x3 #(
  parameter int IMG_HDISP = 640,
  parameter int IMG_VDISP = 480,
  parameter int MORPH_OP  = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic per_frame_vsync,
  input  logic per_frame_href,
  input  logic per_frame_clken,
  input  logic per_img_bit,
  output logic post_frame_vsync,
  output logic post_frame_href,
  output logic post_frame_clken,
  output logic post_img_bit
);

  // Column counter must be able to hold IMG_HDISP itself to saturate there.
  localparam int CW = $clog2(IMG_HDISP + 1);
  localparam int AW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;
  localparam int RW = $clog2(IMG_VDISP) + 1;

  logic [CW-1:0]        r_col_cnt;
  logic [RW-1:0]        r_row_cnt;
  logic                 r_vsync_d;
  logic                 r_href_d;
  logic                 r_vsync_s1, r_href_s1, r_clken_s1;
  logic                 r_vsync_s2, r_href_s2, r_clken_s2;
  logic                 r_pix_d;
  logic                 r_post_bit;
  logic [IMG_HDISP-1:0] r_lb1;
  logic [IMG_HDISP-1:0] r_lb2;
  // Window columns, newest first; bit 2 = row r, bit 1 = row r-1, bit 0 = row r-2
  logic [2:0]           r_win0, r_win1, r_win2;

  logic          w_vsync_rise;
  logic          w_href_fall;
  logic          w_pix;
  logic          w_in_img;
  logic [AW-1:0] w_addr;
  logic [RW-1:0] w_row;
  logic          w_lb1;
  logic          w_lb2;
  logic [2:0]    w_col;
  logic [8:0]    w_taps;
  logic          w_op;

  assign w_vsync_rise = per_frame_vsync & ~r_vsync_d;
  assign w_href_fall  = r_href_d & ~per_frame_href;
  // A strobe coinciding with the href fall still belongs to the line just ending.
  assign w_pix        = per_frame_clken & (per_frame_href | w_href_fall);
  assign w_in_img     = (r_col_cnt < CW'(IMG_HDISP));
  assign w_addr       = r_col_cnt[AW-1:0];
  assign w_row        = w_vsync_rise ? '0 : r_row_cnt;
  assign w_lb1        = r_lb1[w_addr];
  assign w_lb2        = r_lb2[w_addr];
  assign w_col        = w_in_img ? {per_img_bit,
                                    w_lb1 & (w_row >= RW'(1)),
                                    w_lb2 & (w_row >= RW'(2))} : 3'b000;
  assign w_taps       = {r_win0, r_win1, r_win2};
  assign w_op         = (MORPH_OP != 0) ? (&w_taps) : (|w_taps);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_cnt  <= '0;
      r_row_cnt  <= '0;
      r_vsync_d  <= 1'b0;
      r_href_d   <= 1'b0;
      r_vsync_s1 <= 1'b0;
      r_href_s1  <= 1'b0;
      r_clken_s1 <= 1'b0;
      r_vsync_s2 <= 1'b0;
      r_href_s2  <= 1'b0;
      r_clken_s2 <= 1'b0;
      r_pix_d    <= 1'b0;
      r_post_bit <= 1'b0;
      r_win0     <= 3'b000;
      r_win1     <= 3'b000;
      r_win2     <= 3'b000;
    end else begin
      r_vsync_d  <= per_frame_vsync;
      r_href_d   <= per_frame_href;
      r_vsync_s1 <= per_frame_vsync;
      r_href_s1  <= per_frame_href;
      r_clken_s1 <= per_frame_clken;
      r_vsync_s2 <= r_vsync_s1;
      r_href_s2  <= r_href_s1;
      r_clken_s2 <= r_clken_s1;

      if (!per_frame_href) begin
        r_col_cnt <= '0;
      end else if (per_frame_clken && w_in_img) begin
        r_col_cnt <= r_col_cnt + CW'(1);
      end

      if (w_vsync_rise) begin
        r_row_cnt <= '0;
      end else if (w_href_fall && (r_row_cnt < RW'(IMG_VDISP))) begin
        r_row_cnt <= r_row_cnt + RW'(1);
      end

      if (w_pix) begin
        r_win2 <= r_win1;
        r_win1 <= r_win0;
        r_win0 <= w_col;
      end else if (!per_frame_href) begin
        r_win0 <= 3'b000;
        r_win1 <= 3'b000;
        r_win2 <= 3'b000;
      end

      r_pix_d <= w_pix;
      if (r_pix_d) begin
        r_post_bit <= w_op;
      end
    end
  end

  // Line buffers carry no reset; rows not yet valid are masked by the row count.
  always_ff @(posedge clk) begin
    if (w_pix && w_in_img) begin
      r_lb2[w_addr] <= w_lb1;
      r_lb1[w_addr] <= per_img_bit;
    end
  end

  assign post_frame_vsync = r_vsync_s2;
  assign post_frame_href  = r_href_s2;
  assign post_frame_clken = r_clken_s2;
  assign post_img_bit     = r_post_bit;

endmodule
